// File: rtl/spi_master_param_if.sv
// CPU-side handshake and SPI pin bundle for spi_master_param.
// With SPI_LOOPBACK_EN defined the bundle also carries the loopback select.
//
// Handshake: start is a one-cycle request. The master takes it only while busy=0
// and ignores it otherwise, with no queuing. busy stays high from the cycle after
// acceptance through the done cycle. done pulses for one cycle, and rxData holds
// from that cycle until the next accepted start.
interface spi_master_param_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             cpol;
   logic             cpha;
   logic [WIDTH-1:0] txData;
   logic [WIDTH-1:0] rxData;
   logic             busy;
   logic             done;
   logic             sclk;
   logic             mosi;
   logic             miso;
   logic             csN;
`ifdef SPI_LOOPBACK_EN
   logic             loopback;

   modport master (
      input  start, cpol, cpha, txData, miso, loopback,
      output rxData, busy, done, sclk, mosi, csN
   );
   modport slave (
      output start, cpol, cpha, txData, miso, loopback,
      input  rxData, busy, done, sclk, mosi, csN
   );
`else
   modport master (
      input  start, cpol, cpha, txData, miso,
      output rxData, busy, done, sclk, mosi, csN
   );
   modport slave (
      output start, cpol, cpha, txData, miso,
      input  rxData, busy, done, sclk, mosi, csN
   );
`endif
endinterface

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: all four CPOL/CPHA modes, MSB/LSB order, chip select.
// Optional feature macro SPI_LOOPBACK_EN: samples internal mosi instead of miso when loopback=1.
module spi_master_param #(
   parameter int WIDTH     = 8,
   parameter int CLK_DIV   = 2,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic                      clk,
   input  logic                      reset,
   spi_master_param_if.master        bus,
   output logic [2:0]                state_dbg
);
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEAD  = 3'd1,
      XFER  = 3'd2,
      TRAIL = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int                DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int                HALF_W    = $clog2(2 * WIDTH);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * WIDTH - 1);

   state_t            state;
   logic [DIV_W-1:0]  div_cnt;
   logic [HALF_W-1:0] half_cnt;
   logic [WIDTH-1:0]  tx_shift;
   logic [WIDTH-1:0]  rx_shift;
   logic [WIDTH-1:0]  tx_next;
   logic [WIDTH-1:0]  rx_next;
   logic              cpol_q;
   logic              cpha_q;
   logic              din;
   logic              leading_edge;
   logic              sample_edge;
   logic              update_edge;

   function automatic logic out_bit(input logic [WIDTH-1:0] v);
      return LSB_FIRST ? v[0] : v[WIDTH-1];
   endfunction

   assign state_dbg = state;

   always_comb begin
      tx_next      = LSB_FIRST ? (tx_shift >> 1) : (tx_shift << 1);
`ifdef SPI_LOOPBACK_EN
      din          = bus.loopback ? bus.mosi : bus.miso;
`else
      din          = bus.miso;
`endif
      rx_next      = LSB_FIRST ? {din, rx_shift[WIDTH-1:1]} : {rx_shift[WIDTH-2:0], din};
      // Even half-periods end in an idle->active toggle.
      leading_edge = ~half_cnt[0];
      sample_edge  = (half_cnt[0] == cpha_q);
      // The first bit is already on mosi from LEAD; later bits follow the mode's update edge.
      update_edge  = cpha_q ? (leading_edge && (half_cnt != '0))
                            : (!leading_edge && (half_cnt != HALF_LAST));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         div_cnt    <= '0;
         half_cnt   <= '0;
         tx_shift   <= '0;
         rx_shift   <= '0;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         bus.rxData <= '0;
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
         bus.sclk   <= 1'b0;
         bus.mosi   <= 1'b0;
         bus.csN    <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               bus.sclk <= cpol_q;
               bus.csN  <= 1'b1;
               bus.done <= 1'b0;
               if (bus.start) begin
                  tx_shift <= bus.txData;
                  rx_shift <= '0;
                  cpol_q   <= bus.cpol;
                  cpha_q   <= bus.cpha;
                  bus.sclk <= bus.cpol;
                  bus.mosi <= out_bit(bus.txData);
                  bus.csN  <= 1'b0;
                  bus.busy <= 1'b1;
                  div_cnt  <= '0;
                  half_cnt <= '0;
                  state    <= LEAD;
               end
            end
            LEAD: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  state   <= XFER;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            XFER: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt  <= '0;
                  bus.sclk <= ~bus.sclk;
                  if (sample_edge) rx_shift <= rx_next;
                  if (update_edge) begin
                     tx_shift <= tx_next;
                     bus.mosi <= out_bit(tx_next);
                  end
                  if (half_cnt == HALF_LAST) begin
                     half_cnt <= '0;
                     state    <= TRAIL;
                  end else begin
                     half_cnt <= half_cnt + 1'b1;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            TRAIL: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt    <= '0;
                  bus.done   <= 1'b1;
                  bus.csN    <= 1'b1;
                  bus.rxData <= rx_shift;
                  state      <= DONE;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            DONE: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_master_param.sv
// Randomized self-checking bench for spi_master_param: two configurations, a pin-level slave
// model driven from observed SCLK edges, and word-level expectations.
module tb_spi_master_param;
   localparam int W0 = 8;
   localparam int D0 = 2;
   localparam bit L0 = 1'b0;
   localparam int W1 = 16;
   localparam int D1 = 1;
   localparam bit L1 = 1'b1;
`ifdef SPI_LOOPBACK_EN
   localparam bit HAS_LB = 1'b1;
`else
   localparam bit HAS_LB = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   spi_master_param_if #(.WIDTH(W0)) bus0();
   spi_master_param_if #(.WIDTH(W1)) bus1();
   logic [2:0] state_dbg0;
   logic [2:0] state_dbg1;
   logic       miso_drv;

   assign bus0.miso = miso_drv;
   assign bus1.miso = miso_drv;

   spi_master_param #(.WIDTH(W0), .CLK_DIV(D0), .LSB_FIRST(L0)) u_dut0 (
      .clk(clk), .reset(reset), .bus(bus0.master), .state_dbg(state_dbg0));
   spi_master_param #(.WIDTH(W1), .CLK_DIV(D1), .LSB_FIRST(L1)) u_dut1 (
      .clk(clk), .reset(reset), .bus(bus1.master), .state_dbg(state_dbg1));

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Observation of the instance under test.
   int          cur = 0;
   logic        m_sclk, m_mosi, m_csn, m_busy, m_done;
   logic [31:0] m_rx;
   logic [2:0]  m_state;
   assign m_sclk  = (cur == 0) ? bus0.sclk : bus1.sclk;
   assign m_mosi  = (cur == 0) ? bus0.mosi : bus1.mosi;
   assign m_csn   = (cur == 0) ? bus0.csN  : bus1.csN;
   assign m_busy  = (cur == 0) ? bus0.busy : bus1.busy;
   assign m_done  = (cur == 0) ? bus0.done : bus1.done;
   assign m_rx    = (cur == 0) ? 32'(bus0.rxData) : 32'(bus1.rxData);
   assign m_state = (cur == 0) ? state_dbg0 : state_dbg1;

   // Slave model state.
   int          cur_w = W0;
   bit          cur_lsb = L0;
   logic        cur_pol = 1'b0;
   logic        cur_pha = 1'b0;
   logic [31:0] slave_word = '0;
   logic [31:0] mosi_word = '0;
   int          n_lead = 0, n_trail = 0, n_samp = 0, csn_low = 0, done_cnt = 0;
   logic        prev_sclk = 1'b0, prev_csn = 1'b1;

   function automatic int order_pos(input int i);
      return cur_lsb ? i : (cur_w - 1 - i);
   endfunction

   task automatic sample_mosi();
      if (n_samp < cur_w) mosi_word[order_pos(n_samp)] = m_mosi;
      n_samp++;
   endtask

   always @(negedge clk) begin
      if (!m_csn) csn_low++;
      if (m_done) done_cnt++;
      if (!m_csn && prev_csn) begin
         n_lead   = 0;
         n_trail  = 0;
         n_samp   = 0;
         miso_drv = slave_word[order_pos(0)];
      end else if (!m_csn && (m_sclk != prev_sclk)) begin
         if (m_sclk != cur_pol) begin
            n_lead++;
            if (!cur_pha) sample_mosi();
            else if (n_lead <= cur_w) miso_drv = slave_word[order_pos(n_lead - 1)];
         end else begin
            n_trail++;
            if (cur_pha) sample_mosi();
            else if (n_trail < cur_w) miso_drv = slave_word[order_pos(n_trail)];
         end
      end
      prev_sclk = m_sclk;
      prev_csn  = m_csn;
   end

   task automatic drive(input int k, input logic st, input logic [31:0] tx,
                        input logic pol, input logic pha);
      if (k == 0) begin
         bus0.start = st; bus0.txData = tx[W0-1:0]; bus0.cpol = pol; bus0.cpha = pha;
      end else begin
         bus1.start = st; bus1.txData = tx[W1-1:0]; bus1.cpol = pol; bus1.cpha = pha;
      end
   endtask

   // Called at a falling edge with the target idle; returns at the falling edge after done.
   task automatic run_xfer(input int k, input logic [31:0] tx_in, input logic [31:0] sw_in,
                           input logic pol, input logic pha, input logic lb, input bit inject);
      int          w, d, cyc, exp_cyc;
      logic [31:0] mask, tx, sw, exp_rx;
      w       = (k == 0) ? W0 : W1;
      d       = (k == 0) ? D0 : D1;
      mask    = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      tx      = tx_in & mask;
      sw      = sw_in & mask;
      exp_rx  = lb ? tx : sw;
      exp_cyc = d * (2 * w + 2) + 1;
      cur = k; cur_w = w; cur_lsb = (k == 0) ? L0 : L1;
      cur_pol = pol; cur_pha = pha; slave_word = sw; mosi_word = '0;
      csn_low = 0; done_cnt = 0; n_lead = 0; n_trail = 0;
`ifdef SPI_LOOPBACK_EN
      if (k == 0) bus0.loopback = lb; else bus1.loopback = lb;
`endif
      drive(k, 1'b1, tx, pol, pha);
      @(negedge clk);
      cyc = 1;
      drive(k, 1'b0, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("busy_rise", 32'(m_busy), 32'd1);
      check("csn_low_c1", 32'(m_csn), 32'd0);
      while (!m_done && cyc < exp_cyc + 20) begin
         if (inject && cyc == 5) drive(k, 1'b1, $urandom, ~pol, ~pha);
         else drive(k, 1'b0, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         @(negedge clk);
         cyc++;
      end
      drive(k, 1'b0, '0, 1'b0, 1'b0);
      check("done_cycle", 32'(cyc), 32'(exp_cyc));
      check("rx_data", m_rx, exp_rx);
      check("busy_at_done", 32'(m_busy), 32'd1);
      check("csn_at_done", 32'(m_csn), 32'd1);
      @(negedge clk);
      check("done_count", 32'(done_cnt), 32'd1);
      check("csn_low_cycles", 32'(csn_low), 32'(exp_cyc - 1));
      check("sclk_leading", 32'(n_lead), 32'(w));
      check("sclk_trailing", 32'(n_trail), 32'(w));
      check("mosi_word", mosi_word, tx);
      check("sclk_idle", 32'(m_sclk), 32'(pol));
      check("busy_after", 32'(m_busy), 32'd0);
      check("rx_hold", m_rx, exp_rx);
      check("state_idle", 32'(m_state), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 1'b0, '0, 1'b0, 1'b0);
      drive(1, 1'b0, '0, 1'b0, 1'b0);
`ifdef SPI_LOOPBACK_EN
      bus0.loopback = 1'b0;
      bus1.loopback = 1'b0;
`endif
      miso_drv = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_rx", m_rx, 32'd0);
      check("rst_busy", 32'(m_busy), 32'd0);
      check("rst_done", 32'(m_done), 32'd0);
      check("rst_sclk", 32'(m_sclk), 32'd0);
      check("rst_mosi", 32'(m_mosi), 32'd0);
      check("rst_csn", 32'(m_csn), 32'd1);
      check("rst_state", 32'(m_state), 32'd0);
      check("rst_csn1", 32'(bus1.csN), 32'd1);
      reset = 1'b0;
      @(negedge clk);

      // Directed: all four modes on the 8-bit MSB-first instance.
      for (int m = 0; m < 4; m++)
         run_xfer(0, 32'hA5, 32'h3C, 1'(m >> 1), 1'(m & 1), 1'b0, 1'b0);
      // LSB-first single-bit patterns.
      run_xfer(1, 32'h0001, 32'h8000, 1'b0, 1'b0, 1'b0, 1'b0);
      run_xfer(1, 32'h8000, 32'h0001, 1'b1, 1'b1, 1'b0, 1'b0);
      // Start pulsed mid-transfer, then an immediate back-to-back start.
      run_xfer(0, 32'h5A, 32'hC3, 1'b0, 1'b1, 1'b0, 1'b1);
      run_xfer(0, 32'h81, 32'h7E, 1'b1, 1'b0, 1'b0, 1'b0);
      if (HAS_LB) run_xfer(1, 32'hBEEF, 32'h1234, 1'b0, 1'b0, 1'b1, 1'b0);

      for (int i = 0; i < 24; i++)
         run_xfer(i % 2, $urandom, $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), HAS_LB ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);

      // Reset at cycle 10 of a transfer.
      cur = 0; cur_w = W0; cur_lsb = L0; cur_pol = 1'b1; cur_pha = 1'b0;
      drive(0, 1'b1, 32'hA5, 1'b1, 1'b0);
      @(negedge clk);
      drive(0, 1'b0, '0, 1'b0, 1'b0);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      done_cnt = 0;
      check("mid_rst_csn", 32'(m_csn), 32'd1);
      check("mid_rst_sclk", 32'(m_sclk), 32'd0);
      check("mid_rst_busy", 32'(m_busy), 32'd0);
      check("mid_rst_rx", m_rx, 32'd0);
      check("mid_rst_state", 32'(m_state), 32'd0);
      repeat (50) @(negedge clk);
      check("mid_rst_no_done", 32'(done_cnt), 32'd0);

      // Start coincident with reset.
      reset = 1'b1;
      drive(0, 1'b1, 32'hFF, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      drive(0, 1'b0, '0, 1'b0, 1'b0);
      check("rst_start_busy", 32'(m_busy), 32'd0);
      check("rst_start_csn", 32'(m_csn), 32'd1);
      @(negedge clk);
      check("rst_start_idle", 32'(m_state), 32'd0);

      // Normal operation after the reset tests.
      run_xfer(0, 32'h3C, 32'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
